// File: rtl/sb_ram_256x16.sv
// 256x16 synchronous RAM, one read port and one write port, per-bit write mask.
// Optional SB_RAM_256X16_WRITE_THROUGH_EN: a same-address read returns the new word.
module sb_ram_256x16 #(
  parameter logic [255:0] INIT_0 = 256'h0,
  parameter logic [255:0] INIT_1 = 256'h0,
  parameter logic [255:0] INIT_2 = 256'h0,
  parameter logic [255:0] INIT_3 = 256'h0,
  parameter logic [255:0] INIT_4 = 256'h0,
  parameter logic [255:0] INIT_5 = 256'h0,
  parameter logic [255:0] INIT_6 = 256'h0,
  parameter logic [255:0] INIT_7 = 256'h0,
  parameter logic [255:0] INIT_8 = 256'h0,
  parameter logic [255:0] INIT_9 = 256'h0,
  parameter logic [255:0] INIT_A = 256'h0,
  parameter logic [255:0] INIT_B = 256'h0,
  parameter logic [255:0] INIT_C = 256'h0,
  parameter logic [255:0] INIT_D = 256'h0,
  parameter logic [255:0] INIT_E = 256'h0,
  parameter logic [255:0] INIT_F = 256'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_raddr,
  input  logic        i_rclke,
  input  logic        i_re,
  output logic [15:0] o_rdata,
  input  logic [7:0]  i_waddr,
  input  logic        i_wclke,
  input  logic        i_we,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_mask
);

  // INIT_0 sits in the LSBs, so element a of the packed array is word a.
  localparam logic [4095:0] INIT_ALL = {INIT_F, INIT_E, INIT_D, INIT_C,
                                        INIT_B, INIT_A, INIT_9, INIT_8,
                                        INIT_7, INIT_6, INIT_5, INIT_4,
                                        INIT_3, INIT_2, INIT_1, INIT_0};

  logic [255:0][15:0] mem_q = INIT_ALL;
  logic [15:0]        rdata_q, rdata_d;
  logic [15:0]        wr_word_d;
  logic               rd_en, wr_en;

  always_comb begin
    rd_en     = i_rclke & i_re;
    wr_en     = i_wclke & i_we;
    // Mask bit 1 keeps the stored bit.
    wr_word_d = (mem_q[i_waddr] & i_mask) | (i_wdata & ~i_mask);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[i_raddr];
`ifdef SB_RAM_256X16_WRITE_THROUGH_EN
      if (wr_en && (i_waddr == i_raddr)) rdata_d = wr_word_d;
`endif
    end
  end

  // Storage is never reset; writes are only suppressed while reset is held.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_en) mem_q[i_waddr] <= wr_word_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdata_q <= 16'h0000;
    else          rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_sb_ram_256x16.sv
// Randomized self-checking bench for sb_ram_256x16 against an array reference model.
module tb_sb_ram_256x16;

  localparam logic [255:0] P_INIT_0 = 256'hf17406a7b1fe5d747dc385be5b01aa985ed582a411f1c25bdba5fbcf44912f98;
  localparam logic [255:0] P_INIT_3 = 256'h78f2a3f76cebfffa02087814636f82ee6ff3ca4faa4a0cb3bcb5774c6c08c116;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_raddr = '0;
  logic        i_rclke = 1'b0;
  logic        i_re = 1'b0;
  logic [15:0] o_rdata;
  logic [7:0]  i_waddr = '0;
  logic        i_wclke = 1'b0;
  logic        i_we = 1'b0;
  logic [15:0] i_wdata = '0;
  logic [15:0] i_mask = '0;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_mem [256];
  logic [15:0] exp_rdata;

  sb_ram_256x16 #(.INIT_0(P_INIT_0), .INIT_3(P_INIT_3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_raddr(i_raddr), .i_rclke(i_rclke), .i_re(i_re), .o_rdata(o_rdata),
    .i_waddr(i_waddr), .i_wclke(i_wclke), .i_we(i_we),
    .i_wdata(i_wdata), .i_mask(i_mask)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_init();
    logic [255:0] row;
    for (int a = 0; a < 256; a++) begin
      case (a / 16)
        0:       row = P_INIT_0;
        3:       row = P_INIT_3;
        default: row = '0;
      endcase
      exp_mem[a] = 16'(row >> (16 * (a % 16)));
    end
    exp_rdata = 16'h0000;
  endtask

  // Drive one clock of stimulus (called at a negedge) and advance the model.
  task automatic do_op(input logic rclke, input logic re, input logic [7:0] raddr,
                       input logic wclke, input logic we, input logic [7:0] waddr,
                       input logic [15:0] wdata, input logic [15:0] mask);
    logic [15:0] merged;
    i_rclke = rclke; i_re = re; i_raddr = raddr;
    i_wclke = wclke; i_we = we; i_waddr = waddr;
    i_wdata = wdata; i_mask = mask;
    merged = 16'h0;
    for (int b = 0; b < 16; b++)
      merged[b] = mask[b] ? exp_mem[waddr][b] : wdata[b];
    if (i_rst_n) begin
      if (rclke && re) begin
        exp_rdata = exp_mem[raddr];
`ifdef SB_RAM_256X16_WRITE_THROUGH_EN
        if (wclke && we && waddr == raddr) exp_rdata = merged;
`endif
      end
      if (wclke && we) exp_mem[waddr] = merged;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_re = 1'b0; i_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    do_op(1'b1, 1'b1, a, 1'b0, 1'b0, 8'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    total++;
    if (o_rdata !== 16'h0000) begin
      bad++; $display("FAIL reset_value: got %h want 0000", o_rdata);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_init_reads();
    logic [7:0]  addrs [5] = '{8'd0, 8'd1, 8'd15, 8'd63, 8'd64};
    logic [15:0] wants [5] = '{16'h2f98, 16'h4491, 16'hf174, 16'h78f2, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i]);
      total++;
      if (o_rdata !== wants[i]) begin
        bad++; $display("FAIL init_read a=%0d: got %h want %h", addrs[i], o_rdata, wants[i]);
      end
    end
  endtask

  task automatic test_masked_write();
    do_op(1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 8'd5, 16'hFFFF, 16'h00FF);
    rd(8'd5);
    total++;
    if (o_rdata !== 16'hFFF1) begin
      bad++; $display("FAIL masked_write: got %h want fff1", o_rdata);
    end
    do_op(1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 8'd5, 16'h0000, 16'hFFFF);
    rd(8'd5);
    total++;
    if (o_rdata !== 16'hFFF1) begin
      bad++; $display("FAIL full_mask_write: got %h want fff1", o_rdata);
    end
  endtask

  task automatic test_hold();
    rd(8'd0);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b0, 8'h0, 16'h0, 16'h0);
      total++;
      if (o_rdata !== 16'h2f98) begin
        bad++; $display("FAIL hold_re0: got %h want 2f98", o_rdata);
      end
      do_op(1'b0, 1'b1, 8'(i + 7), 1'b0, 1'b0, 8'h0, 16'h0, 16'h0);
      total++;
      if (o_rdata !== 16'h2f98) begin
        bad++; $display("FAIL hold_rclke0: got %h want 2f98", o_rdata);
      end
    end
  endtask

  task automatic test_async_reset();
    rd(8'd0);
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (o_rdata !== 16'h0000) begin
      bad++; $display("FAIL async_reset: got %h want 0000", o_rdata);
    end
    @(negedge i_clk);
    exp_rdata = 16'h0000;
    do_op(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0, 16'h5555, 16'h0000);
    total++;
    if (o_rdata !== 16'h0000) begin
      bad++; $display("FAIL reset_hold: got %h want 0000", o_rdata);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    rd(8'd0);
    total++;
    if (o_rdata !== 16'h2f98) begin
      bad++; $display("FAIL post_reset_read: got %h want 2f98", o_rdata);
    end
  endtask

  task automatic test_same_addr();
    logic [15:0] want;
`ifdef SB_RAM_256X16_WRITE_THROUGH_EN
    want = 16'h1234;
`else
    want = 16'hfbcf;
`endif
    do_op(1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 16'h1234, 16'h0000);
    total++;
    if (o_rdata !== want) begin
      bad++; $display("FAIL same_addr_rdw: got %h want %h", o_rdata, want);
    end
    rd(8'd2);
    total++;
    if (o_rdata !== 16'h1234) begin
      bad++; $display("FAIL same_addr_after: got %h want 1234", o_rdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, wa;
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      wa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_op(1'($urandom), 1'($urandom), ra, 1'($urandom), 1'($urandom), wa,
            16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      total++;
      if (o_rdata !== exp_rdata) begin
        bad++; $display("FAIL random_op %0d: got %h want %h", i, o_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      rd(8'(a));
      total++;
      if (o_rdata !== exp_mem[a]) begin
        bad++; $display("FAIL sweep a=%0d: got %h want %h", a, o_rdata, exp_mem[a]);
      end
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_init_reads();
    test_masked_write();
    test_hold();
    test_async_reset();
    test_same_addr();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_ram_256x16.md
SB_RAM_256X16 -- requirements
Module: sb_ram_256x16

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- INIT_0 .. INIT_F, 256'h0 each: initial contents; INIT_n bits [16k+15:16k] = word at address 16n+k (k=0..15, address 16n in LSBs).

REQ-002 Ports, one per line (name, direction, width, meaning):
- i_clk  input  1  single clock; all sequential activity on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_raddr  input  8  read address.
- i_rclke  input  1  read clock enable.
- i_re  input  1  read enable.
- o_rdata  output  16  registered read data.
- i_waddr  input  8  write address.
- i_wclke  input  1  write clock enable.
- i_we  input  1  write enable.
- i_wdata  input  16  write data.
- i_mask  input  16  per-bit write mask; 1 = bit NOT written, 0 = bit written.

Function
REQ-003 Storage SHALL be 256 words x 16 bits, loaded at time zero / configuration from INIT_0..INIT_F per REQ-001.
REQ-004 Read SHALL occur when i_rclke=1 and i_re=1 at a rising i_clk edge: o_rdata <= mem[i_raddr]; 1-cycle latency.
REQ-005 When i_rclke=0 or i_re=0, o_rdata SHALL hold its previous value.
REQ-006 Write SHALL occur when i_wclke=1 and i_we=1 at a rising i_clk edge: for each bit b, mem[i_waddr][b] <= i_mask[b] ? old bit : i_wdata[b].
REQ-007 i_mask=16'hFFFF SHALL leave memory unchanged even with write enabled.
REQ-008 Read and write to different addresses in the same cycle SHALL be independent.
REQ-009 Same-address read and write in one cycle: o_rdata behaviour per REQ-013/REQ-014; memory SHALL always hold the merged new word afterwards.
REQ-010 Addresses SHALL use the full 8-bit range with no wrap or aliasing; addresses beyond the initialised range read the INIT default 0.

Reset
REQ-011 i_rst_n=0 SHALL clear o_rdata to 16'h0000 immediately (asynchronously) and hold it at 0 while asserted; reads and writes SHALL be ignored while asserted.
REQ-012 Reset SHALL NOT alter memory contents; after deassertion the first enabled read returns stored data.

Configuration
REQ-013 With macro SB_RAM_256X16_WRITE_THROUGH_EN defined: a same-address read/write SHALL return the newly merged word on o_rdata in that cycle.
REQ-014 Without SB_RAM_256X16_WRITE_THROUGH_EN: a same-address read/write SHALL return the pre-write (old) word (read-first).

Verification
REQ-015 INIT_0=256'hf17406a7b1fe5d747dc385be5b01aa985ed582a411f1c25bdba5fbcf44912f98, INIT_3=256'h78f2a3f76cebfffa02087814636f82ee6ff3ca4faa4a0cb3bcb5774c6c08c116 -> read addr 0 gives 16'h2f98, addr 1 16'h4491, addr 15 16'hf174, addr 63 16'h78f2, addr 64 16'h0000, each one cycle after the request.
REQ-016 Masked write at addr 5 (init 16'h11f1) with i_wdata=16'hFFFF, i_mask=16'h00FF -> subsequent read gives 16'hFFF1; a repeat with i_mask=16'hFFFF leaves 16'hFFF1.
REQ-017 Read addr 0 valid (16'h2f98), then i_re=0 while i_raddr changes -> o_rdata stays 16'h2f98; same result with i_rclke=0.
REQ-018 Assert i_rst_n=0 mid-cycle while o_rdata=16'h2f98 -> o_rdata becomes 16'h0000 before the next edge; write attempted during reset is ignored; after release, read addr 0 gives 16'h2f98.
REQ-019 Same cycle write 16'h1234 (mask 0) and read at addr 2 (init 16'hfbcf) -> o_rdata 16'hfbcf without the macro, 16'h1234 with it; next read of addr 2 gives 16'h1234 in both builds.
